// File: rtl/emissor_credencial_autenticacao_pkg.sv
// -----------------------------------------------------------------------------
// emissor_credencial_autenticacao_pkg
// Shared definitions for the authentication credential initiator:
//   - estado_t       : controller states (IDLE, SETTLE, CHECK, GRANT, DENY, LOCK)
//   - NIVEL_*        : requested access level encodings
//   - CODE_W         : credential width (lines A..F)
//   - nivel_acerta() : selects the AUT line addressed by a level
// -----------------------------------------------------------------------------
package emissor_credencial_autenticacao_pkg;

  localparam int CODE_W = 6;

  localparam logic [1:0] NIVEL_INVALIDO = 2'd0;
  localparam logic [1:0] NIVEL_AUT1     = 2'd1;
  localparam logic [1:0] NIVEL_AUT2     = 2'd2;
  localparam logic [1:0] NIVEL_AUT3     = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETTLE = 3'd1,
    CHECK  = 3'd2,
    GRANT  = 3'd3,
    DENY   = 3'd4,
    LOCK   = 3'd5
  } estado_t;

  // Level 0 never matches; levels 1..3 pick AUT1..AUT3 (aut bit0..bit2).
  function automatic logic nivel_acerta(input logic [1:0] nivel, input logic [2:0] aut);
    logic acerto;
    case (nivel)
      NIVEL_AUT1: acerto = aut[0];
      NIVEL_AUT2: acerto = aut[1];
      NIVEL_AUT3: acerto = aut[2];
      default:    acerto = 1'b0;
    endcase
    return acerto;
  endfunction

endpackage

// File: rtl/emissor_credencial_autenticacao_contador_descendente.sv
// -----------------------------------------------------------------------------
// contador_descendente
// Loadable down-counter with a zero flag. Load has priority over decrement;
// decrementing stops at zero.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load        : load load_value on the next edge
//   load_value  : value to load
//   dec         : decrement enable
//   count       : current value (registered)
//   zero        : count == 0
// -----------------------------------------------------------------------------
module contador_descendente #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Counter register: reset, load, or saturating decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {W{1'b0}};
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != {W{1'b0}})) begin
      count <= count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

  assign zero = (count == {W{1'b0}});

endmodule

// File: rtl/emissor_credencial_autenticacao.sv
// -----------------------------------------------------------------------------
// emissor_credencial_autenticacao
// Initiator side of the authentication comparator interface. Accepts a
// credential and level over valid/ready, drives it on A..F, samples the
// selected AUT line after a settle window, then issues a timed grant or a
// one-cycle deny. MAX_TRIES consecutive failures start a lockout period.
// Optional feature macro: AUTH_AUDIT_EN (adds grant_total and last_level).
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   req_valid    : request present          req_ready : high iff idle
//   code_in[5:0] : credential (bit5 = A)    level_in  : 0 invalid, 1..3
//   code_out     : credential to comparator (0 outside SETTLE/CHECK)
//   aut_in[2:0]  : comparator results AUT1..AUT3
//   grant, deny, locked, fail_count : registered result outputs
//   grant_total[7:0], last_level[1:0] : audit outputs (AUTH_AUDIT_EN only)
// -----------------------------------------------------------------------------
module emissor_credencial_autenticacao
  import emissor_credencial_autenticacao_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2,
  parameter int GRANT_CYCLES  = 4,
  parameter int MAX_TRIES     = 3,
  parameter int LOCK_CYCLES   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [CODE_W-1:0] code_in,
  input  logic [1:0]        level_in,
  output logic [CODE_W-1:0] code_out,
  input  logic [2:0]        aut_in,
  output logic              grant,
  output logic              deny,
  output logic              locked,
`ifdef AUTH_AUDIT_EN
  output logic [7:0]        grant_total,
  output logic [1:0]        last_level,
`endif
  output logic [2:0]        fail_count
);

  // One counter times SETTLE, GRANT and LOCK, so it is sized for the longest.
  localparam int CNT_MAX_A = (SETTLE_CYCLES > GRANT_CYCLES) ? SETTLE_CYCLES : GRANT_CYCLES;
  localparam int CNT_MAX   = ((CNT_MAX_A > LOCK_CYCLES) ? CNT_MAX_A : LOCK_CYCLES) - 1;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GRANT_LOAD  = CNT_W'(GRANT_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LOAD   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [2:0]       MAX_TRIES_V = 3'(MAX_TRIES);

  estado_t          state;
  logic [1:0]       level_r;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_value_s;
  logic             cnt_dec_s;
  logic [CNT_W-1:0] cnt_count;
  logic             cnt_zero;
  logic             hit_s;
  logic [2:0]       fail_next_s;
  logic             lock_s;

  assign req_ready   = (state == IDLE);
  assign hit_s       = nivel_acerta(level_r, aut_in);
  assign fail_next_s = fail_count + 3'd1;
  assign lock_s      = (fail_next_s >= MAX_TRIES_V);

  contador_descendente #(.W(CNT_W)) u_contador (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load_s),
    .load_value (cnt_value_s),
    .dec        (cnt_dec_s),
    .count      (cnt_count),
    .zero       (cnt_zero)
  );

  // Counter control: load on entry to a timed state, decrement while inside one.
  always_comb begin
    cnt_load_s  = 1'b0;
    cnt_value_s = {CNT_W{1'b0}};
    cnt_dec_s   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          cnt_load_s  = 1'b1;
          cnt_value_s = SETTLE_LOAD;
        end else begin
          cnt_load_s  = 1'b0;
        end
      end
      CHECK: begin
        if (hit_s) begin
          cnt_load_s  = 1'b1;
          cnt_value_s = GRANT_LOAD;
        end else if (lock_s) begin
          cnt_load_s  = 1'b1;
          cnt_value_s = LOCK_LOAD;
        end else begin
          cnt_load_s  = 1'b0;
        end
      end
      SETTLE, GRANT, LOCK: cnt_dec_s = 1'b1;
      default: cnt_dec_s = 1'b0;
    endcase
  end

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      level_r    <= NIVEL_INVALIDO;
      code_out   <= {CODE_W{1'b0}};
      grant      <= 1'b0;
      deny       <= 1'b0;
      locked     <= 1'b0;
      fail_count <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          code_out <= {CODE_W{1'b0}};
          if (req_valid) begin
            code_out <= code_in;
            level_r  <= level_in;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_zero) state <= CHECK;
        end
        CHECK: begin
          code_out <= {CODE_W{1'b0}};
          if (hit_s) begin
            fail_count <= 3'd0;
            grant      <= 1'b1;
            state      <= GRANT;
          end else if (lock_s) begin
            fail_count <= MAX_TRIES_V;
            locked     <= 1'b1;
            deny       <= 1'b1;
            state      <= LOCK;
          end else begin
            fail_count <= fail_next_s;
            deny       <= 1'b1;
            state      <= DENY;
          end
        end
        GRANT: begin
          if (cnt_zero) begin
            grant <= 1'b0;
            state <= IDLE;
          end
        end
        DENY: begin
          deny  <= 1'b0;
          state <= IDLE;
        end
        LOCK: begin
          deny <= 1'b0;
          if (cnt_zero) begin
            fail_count <= 3'd0;
            locked     <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          code_out <= {CODE_W{1'b0}};
          grant    <= 1'b0;
          deny     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

`ifdef AUTH_AUDIT_EN
  // Audit history: saturating grant count and level of the latest check.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_total <= 8'd0;
      last_level  <= NIVEL_INVALIDO;
    end else if (state == CHECK) begin
      last_level <= level_r;
      if (hit_s && (grant_total != 8'hFF)) grant_total <= grant_total + 8'd1;
    end
  end
`else
  // No audit history is kept in this build.
`endif

endmodule

// File: doc/emissor_credencial_autenticacao.md
Name: emissor_credencial_autenticacao

Overview:
- Initiator side of the authentication comparator interface.
- Accepts a 6-bit credential and a requested access level (1..3) via a valid/ready handshake, then drives the credential onto the comparator's A..F lines.
- After a settle window it samples the selected AUT1..AUT3 result and issues a timed grant or a one-cycle deny.
- Counts consecutive failures and enforces a lockout period after MAX_TRIES failures.

Parameters:
- SETTLE_CYCLES, default 2: cycles code_out is held before sampling aut_in; legal range is 1 or more.
- GRANT_CYCLES, default 4: number of cycles grant stays high.
- MAX_TRIES, default 3: consecutive failures that trigger lockout; legal range is 1..7.
- LOCK_CYCLES, default 16: lockout duration in cycles.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  credential request present.
- req_ready  out  1  block can accept a request.
- code_in  in  6  credential; bit5..bit0 map to A..F.
- level_in  in  2  requested level: 1=AUT1, 2=AUT2, 3=AUT3, 0=invalid.
- code_out  out  6  drives comparator inputs A..F (bit5=A).
- aut_in  in  3  comparator results; bit0=AUT1, bit1=AUT2, bit2=AUT3.
- grant  out  1  access granted.
- deny  out  1  one-cycle failure pulse.
- locked  out  1  lockout active.
- fail_count  out  3  consecutive failure count.

Behaviour:
- Reset: takes effect at any point, including mid-operation. State goes to IDLE; code_out=0, grant=0, deny=0, locked=0, fail_count=0. req_ready=1 in the first cycle after reset.
- All outputs are registered except req_ready, which is high iff state==IDLE.
- IDLE:
  - code_out=0, so the credential is never exposed while idle.
  - On req_valid && req_ready: latch code_in to code_out and level_in to a level register; load the counter with SETTLE_CYCLES-1; go to SETTLE.
  - req_valid while not ready is ignored. There is no queue, and the requester must hold the request.
- SETTLE: hold code_out. Decrement the counter; at 0 go to CHECK.
- CHECK (exactly one cycle): hit = (level != 0) && aut_in[level-1]. aut_in is sampled only here.
  - Hit: fail_count<=0; counter<=GRANT_CYCLES-1; go to GRANT.
  - Miss with fail_count+1 < MAX_TRIES: fail_count<=fail_count+1; go to DENY.
  - Miss with fail_count+1 == MAX_TRIES: fail_count<=MAX_TRIES; counter<=LOCK_CYCLES-1; go to LOCK.
- GRANT: grant=1 for exactly GRANT_CYCLES cycles; code_out=0; then IDLE.
- DENY: deny=1 for one cycle; code_out=0; then IDLE.
- LOCK:
  - locked=1 and deny=1 in the first LOCK cycle only; code_out=0.
  - After LOCK_CYCLES cycles: fail_count<=0, locked<=0, go to IDLE.
- Latency: with accept on edge E0, CHECK occupies the cycle after edge E(SETTLE_CYCLES). grant or deny becomes visible after edge E(SETTLE_CYCLES+1).
- Level 0 always counts as a miss and increments fail_count.
- grant and deny are never high in the same cycle.
- fail_count saturates at MAX_TRIES and never wraps.

Optional Feature:
- Macro: AUTH_AUDIT_EN.
- Defined: adds outputs grant_total[7:0] and last_level[1:0].
  - grant_total increments on each CHECK hit and saturates at 255.
  - last_level holds the level of the most recent CHECK, hit or miss.
  - Both clear on rst.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Package: state enum (IDLE, SETTLE, CHECK, GRANT, DENY, LOCK); level constants NIVEL_INVALIDO=0, NIVEL_AUT1=1, NIVEL_AUT2=2, NIVEL_AUT3=3; code width constant 6.
- One sub-module, contador_descendente: a loadable down-counter with a zero flag, shared by the SETTLE, GRANT and LOCK timing.

Test Plan:
- Grant: reset, then send code_in=6'b011100, level=1, with aut_in=3'b001 held. code_out=6'b011100 appears 1 cycle after accept; grant is high for 4 cycles starting 3 edges after accept; fail_count stays 0; code_out returns to 0 in GRANT.
- Wrong level: aut_in=3'b001, level=2. deny pulses 1 cycle and fail_count=1. Then level=0 with aut_in=3'b111: deny pulses and fail_count=2.
- Lockout: three consecutive misses. Third miss gives locked=1 and a deny pulse; req_ready stays 0 for 16 cycles while req_valid is held high; then locked=0, fail_count=0, req_ready=1.
- Counter clear: two misses then a hit. fail_count goes 1, 2, 0 and grant asserts.
- Reset mid-SETTLE: assert rst one cycle after accept. Next cycle code_out=0, grant=0, fail_count=0, req_ready=1, and no deny occurs.
- Audit (AUTH_AUDIT_EN): 3 grants at level 3 then one miss at level 1. grant_total=3, last_level=1.
